// File: rtl/int_alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : int_alu_arbiter                                                  |
// | Brief    : Round-robin front end sharing one combinational integer ALU      |
// |            between two valid/ready requesters, with a single tagged         |
// |            valid/ready response channel.                                    |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module int_alu_arbiter #(
  parameter int WIDTH   = 4,
  parameter int OPW     = 3,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  input  logic [WIDTH-1:0] alu_o,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             rsp_ready,
  output logic             busy
);

  // Counter only has to hold ALU_LAT-1 down to 0, so it can never wrap.
  localparam int                c_cnt_w    = $clog2(ALU_LAT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(ALU_LAT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_zero = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_rr_ptr;
  logic                 r_owner;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 w_idle;
  logic                 w_grant0;
  logic                 w_grant1;
  logic                 w_accept;
  logic                 w_rsp_done;

  // Grant is recomputed every cycle; the pointer only breaks ties.
  assign w_idle     = (r_state == S_IDLE) && !rst;
  assign w_grant0   = w_idle && req0_valid && (!req1_valid || !r_rr_ptr);
  assign w_grant1   = w_idle && req1_valid && (!req0_valid ||  r_rr_ptr);
  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign w_accept   = w_grant0 || w_grant1;
  assign w_rsp_done = rsp_valid && rsp_ready;
  assign busy       = (r_state != S_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic for the IDLE -> BUSY -> RESP -> IDLE cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)            w_state_nxt = S_BUSY;
      S_BUSY:  if (r_cnt == c_cnt_zero) w_state_nxt = S_RESP;
      S_RESP:  if (w_rsp_done)          w_state_nxt = S_IDLE;
      default:                          w_state_nxt = S_IDLE;
    endcase
  end

  // Operand launch, latency count, result capture and round-robin update.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op    <= '0;
      alu_x     <= '0;
      alu_y     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      r_owner   <= 1'b0;
      r_cnt     <= c_cnt_zero;
      r_rr_ptr  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            alu_op  <= w_grant1 ? req1_op : req0_op;
            alu_x   <= w_grant1 ? req1_x  : req0_x;
            alu_y   <= w_grant1 ? req1_y  : req0_y;
            r_owner <= w_grant1;
            r_cnt   <= c_cnt_init;
          end
        end
        S_BUSY: begin
          if (r_cnt == c_cnt_zero) begin
            rsp_data  <= alu_o;
            rsp_id    <= r_owner;
            rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - c_cnt_one;
          end
        end
        S_RESP: begin
          if (w_rsp_done) begin
            rsp_valid <= 1'b0;
            r_rr_ptr  <= ~r_owner;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_int_alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_int_alu_arbiter                                               |
// | Brief    : Directed self-checking bench for int_alu_arbiter (ALU_LAT=1 and  |
// |            ALU_LAT=3 instances, each with a behavioural gate-slice ALU).    |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_int_alu_arbiter;

  localparam int WIDTH = 4;
  localparam int OPW   = 3;

  logic clk;
  logic rst;

  // ALU_LAT=1 instance
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [OPW-1:0]   req0_op, req1_op, alu_op;
  logic [WIDTH-1:0] req0_x, req0_y, req1_x, req1_y, alu_x, alu_y, alu_o;
  logic             rsp_valid, rsp_id, rsp_ready, busy;
  logic [WIDTH-1:0] rsp_data;

  // ALU_LAT=3 instance
  logic             l3_req0_valid, l3_req0_ready, l3_req1_valid, l3_req1_ready;
  logic [OPW-1:0]   l3_req0_op, l3_req1_op, l3_alu_op;
  logic [WIDTH-1:0] l3_req0_x, l3_req0_y, l3_req1_x, l3_req1_y;
  logic [WIDTH-1:0] l3_alu_x, l3_alu_y, l3_alu_o;
  logic             l3_rsp_valid, l3_rsp_id, l3_rsp_ready, l3_busy;
  logic [WIDTH-1:0] l3_rsp_data;

  int n_total = 0;
  int n_pass  = 0;

  // Gate-slice ALU: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 NAND, 5 XNOR, 6 NOT x, 7 pass x.
  function automatic logic [WIDTH-1:0] alu_fn(input logic [OPW-1:0] op,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    case (op)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return x ^ y;
      3'd3:    return ~(x | y);
      3'd4:    return ~(x & y);
      3'd5:    return ~(x ^ y);
      3'd6:    return ~x;
      default: return x;
    endcase
  endfunction

  assign alu_o    = alu_fn(alu_op, alu_x, alu_y);
  assign l3_alu_o = alu_fn(l3_alu_op, l3_alu_x, l3_alu_y);

  int_alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW), .ALU_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_x(req1_x), .req1_y(req1_y),
    .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y), .alu_o(alu_o),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  int_alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW), .ALU_LAT(3)) u_dut_l3 (
    .clk(clk), .rst(rst),
    .req0_valid(l3_req0_valid), .req0_ready(l3_req0_ready), .req0_op(l3_req0_op),
    .req0_x(l3_req0_x), .req0_y(l3_req0_y),
    .req1_valid(l3_req1_valid), .req1_ready(l3_req1_ready), .req1_op(l3_req1_op),
    .req1_x(l3_req1_x), .req1_y(l3_req1_y),
    .alu_op(l3_alu_op), .alu_x(l3_alu_x), .alu_y(l3_alu_y), .alu_o(l3_alu_o),
    .rsp_valid(l3_rsp_valid), .rsp_id(l3_rsp_id), .rsp_data(l3_rsp_data),
    .rsp_ready(l3_rsp_ready), .busy(l3_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs follow freshly driven inputs.
  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    settle();
  endtask

  initial begin
    int got;
    rst = 1'b1;
    req0_valid = 0; req0_op = '0; req0_x = '0; req0_y = '0;
    req1_valid = 0; req1_op = '0; req1_x = '0; req1_y = '0;
    rsp_ready  = 0;
    l3_req0_valid = 0; l3_req0_op = '0; l3_req0_x = '0; l3_req0_y = '0;
    l3_req1_valid = 0; l3_req1_op = '0; l3_req1_x = '0; l3_req1_y = '0;
    l3_rsp_ready  = 0;

    // Reset state; ready must stay low while rst is high even with a valid request
    step();
    step();
    req0_valid = 1;
    settle();
    chk("rst_ready0", req0_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu_x", alu_x, 0);
    chk("rst_rsp_data", rsp_data, 0);
    req0_valid = 0;
    rst = 0;
    settle();

    // 1: single op, NOR 1111/0000 -> 0000
    req0_valid = 1; req0_op = 3'd3; req0_x = 4'b1111; req0_y = 4'b0000;
    rsp_ready = 1;
    settle();
    chk("t1_ready0", req0_ready, 1);
    chk("t1_ready1", req1_ready, 0);
    step();
    req0_valid = 0;
    chk("t1_busy", busy, 1);
    chk("t1_alu_op", alu_op, 3);
    chk("t1_alu_x", alu_x, 4'hF);
    chk("t1_rsp_pending", rsp_valid, 0);
    step();
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_id", rsp_id, 0);
    chk("t1_rsp_data", rsp_data, 4'b0000);
    step();
    chk("t1_done_valid", rsp_valid, 0);
    chk("t1_done_busy", busy, 0);

    // 2: contention after reset, req0 first then req1
    do_reset();
    req0_valid = 1; req0_op = 3'd3; req0_x = 4'b0000; req0_y = 4'b0110;
    req1_valid = 1; req1_op = 3'd3; req1_x = 4'b1111; req1_y = 4'b1111;
    rsp_ready = 1;
    settle();
    chk("t2_ready0", req0_ready, 1);
    chk("t2_ready1", req1_ready, 0);
    step();
    req0_valid = 0;
    settle();
    chk("t2_busy_ready1", req1_ready, 0);
    step();
    chk("t2_rsp0_valid", rsp_valid, 1);
    chk("t2_rsp0_id", rsp_id, 0);
    chk("t2_rsp0_data", rsp_data, 4'b1001);
    step();
    chk("t2_ready1_idle", req1_ready, 1);
    step();
    req1_valid = 0;
    step();
    chk("t2_rsp1_valid", rsp_valid, 1);
    chk("t2_rsp1_id", rsp_id, 1);
    chk("t2_rsp1_data", rsp_data, 4'b0000);
    step();

    // 3: fairness, both held valid for 6 responses
    req0_valid = 1; req0_op = 3'd0; req0_x = 4'hC; req0_y = 4'hA;
    req1_valid = 1; req1_op = 3'd1; req1_x = 4'hC; req1_y = 4'hA;
    rsp_ready = 1;
    settle();
    got = 0;
    for (int c = 0; c < 60 && got < 6; c++) begin
      step();
      if (rsp_valid) begin
        chk("t3_id", rsp_id, got % 2);
        chk("t3_data", rsp_data, (got % 2 == 0) ? 4'h8 : 4'hE);
        got++;
      end
    end
    req0_valid = 0;
    req1_valid = 0;
    chk("t3_count", got, 6);
    step();
    step();

    // 4: backpressure for 5 cycles, XOR 0101/0011 -> 0110 from req1
    do_reset();
    rsp_ready = 0;
    req1_valid = 1; req1_op = 3'd2; req1_x = 4'b0101; req1_y = 4'b0011;
    settle();
    chk("t4_ready1", req1_ready, 1);
    step();
    req1_valid = 0;
    step();
    req0_valid = 1;
    req1_valid = 1;
    settle();
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", rsp_valid, 1);
      chk("t4_hold_data", rsp_data, 4'b0110);
      chk("t4_hold_id", rsp_id, 1);
      chk("t4_hold_ready0", req0_ready, 0);
      chk("t4_hold_ready1", req1_ready, 0);
      chk("t4_hold_busy", busy, 1);
      step();
    end
    rsp_ready = 1;
    settle();
    chk("t4_pre_hs_valid", rsp_valid, 1);
    step();
    chk("t4_hs_valid", rsp_valid, 0);
    chk("t4_hs_busy", busy, 0);
    chk("t4_rr_ready0", req0_ready, 1);
    req0_valid = 0;
    req1_valid = 0;
    step();
    step();

    // 5: reset while BUSY discards the op
    req0_valid = 1; req0_op = 3'd3; req0_x = 4'b0000; req0_y = 4'b0000;
    rsp_ready = 1;
    settle();
    step();
    req0_valid = 0;
    chk("t5_busy_before", busy, 1);
    rst = 1;
    step();
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_valid", rsp_valid, 0);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_no_stale", rsp_valid, 0);
    end
    req1_valid = 1; req1_op = 3'd3; req1_x = 4'b0001; req1_y = 4'b0010;
    settle();
    chk("t5_ready1", req1_ready, 1);
    step();
    req1_valid = 0;
    step();
    chk("t5_rsp_valid", rsp_valid, 1);
    chk("t5_rsp_id", rsp_id, 1);
    chk("t5_rsp_data", rsp_data, 4'b1100);
    step();

    // 6: ALU_LAT=3 instance, OR 1001/0100 -> 1101
    do_reset();
    l3_rsp_ready = 1;
    l3_req0_valid = 1; l3_req0_op = 3'd1; l3_req0_x = 4'b1001; l3_req0_y = 4'b0100;
    settle();
    chk("t6_ready0", l3_req0_ready, 1);
    step();
    l3_req0_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("t6_alu_op", l3_alu_op, 3'd1);
      chk("t6_alu_x", l3_alu_x, 4'b1001);
      chk("t6_alu_y", l3_alu_y, 4'b0100);
      chk("t6_not_yet", l3_rsp_valid, 0);
      chk("t6_busy", l3_busy, 1);
      step();
    end
    chk("t6_rsp_valid", l3_rsp_valid, 1);
    chk("t6_rsp_id", l3_rsp_id, 0);
    chk("t6_rsp_data", l3_rsp_data, 4'b1101);
    step();
    chk("t6_done", l3_rsp_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
